// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates synchronous exceptions, interrupts and CSR/MRET
// instructions onto one CSR-unit port and returns completion/redirect responses.
module trap_sequencer #(
  parameter int MIN_GAP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_req,
  input  logic [3:0]  exc_code,
  input  logic        instr_req,
  input  logic [2:0]  instr_op,
  input  logic [11:0] instr_addr,
  input  logic [31:0] instr_wdata,
  input  logic [31:0] pc,
  input  logic        at_boundary,
  output logic        req_ack,
  output logic        csr_available,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic        csr_busy,
  input  logic        csr_fault,
  input  logic [31:0] csr_read_value,
  input  logic        ext_int_pending,
  input  logic        sw_int_pending,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect
);

  localparam int          GW         = $clog2(MIN_GAP);
  localparam logic [2:0]  OP_TRAP    = 3'b000;
  localparam logic [11:0] ADDR_EXT   = 12'h01B;
  localparam logic [11:0] ADDR_SW    = 12'h013;
  localparam logic [11:0] ADDR_ILLEG = 12'h002;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic          busy_prev_r;
  logic          is_instr_r, is_instr_s;
  logic          retrap_r, retrap_s;
  logic [31:0]   pc_r, pc_s;
  logic          avail_r, avail_s;
  logic [2:0]    op_r, op_s;
  logic [11:0]   addr_r, addr_s;
  logic [31:0]   wdata_r, wdata_s;
  logic          resp_valid_r, resp_valid_s;
  logic [31:0]   rdata_r, rdata_s;
  logic          redirect_r, redirect_s;
  logic          ack_s;
  logic          done_s;

  assign done_s = busy_prev_r & ~csr_busy;

  // Next-state, arbitration and response generation
  always_comb begin
    state_s      = state_r;
    gap_cnt_s    = gap_cnt_r;
    is_instr_s   = is_instr_r;
    retrap_s     = retrap_r;
    pc_s         = pc_r;
    avail_s      = avail_r;
    op_s         = op_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    resp_valid_s = 1'b0;
    rdata_s      = rdata_r;
    redirect_s   = redirect_r;
    ack_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (exc_req) begin
          ack_s      = 1'b1;
          state_s    = RUN;
          avail_s    = 1'b1;
          op_s       = OP_TRAP;
          addr_s     = {8'h00, exc_code};
          wdata_s    = pc;
          is_instr_s = 1'b0;
        end else if (ext_int_pending && at_boundary) begin
          state_s    = RUN;
          avail_s    = 1'b1;
          op_s       = OP_TRAP;
          addr_s     = ADDR_EXT;
          wdata_s    = pc;
          is_instr_s = 1'b0;
        end else if (sw_int_pending && at_boundary) begin
          state_s    = RUN;
          avail_s    = 1'b1;
          op_s       = OP_TRAP;
          addr_s     = ADDR_SW;
          wdata_s    = pc;
          is_instr_s = 1'b0;
        end else if (instr_req) begin
          ack_s      = 1'b1;
          state_s    = RUN;
          avail_s    = 1'b1;
          op_s       = instr_op;
          addr_s     = instr_addr;
          wdata_s    = instr_wdata;
          pc_s       = pc;
          is_instr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (done_s) begin
          state_s   = GAP;
          gap_cnt_s = '0;
          avail_s   = 1'b0;
          if (csr_fault) begin
            // a faulting instruction owes the core an illegal-instruction trap
            retrap_s = is_instr_r;
          end else begin
            resp_valid_s = 1'b1;
            rdata_s      = csr_read_value;
            redirect_s   = (op_r[2:1] == 2'b00);
          end
        end else begin
          state_s = RUN;
        end
      end
      GAP: begin
        if (gap_cnt_r == GW'(MIN_GAP - 1)) begin
          if (retrap_r) begin
            state_s    = RUN;
            avail_s    = 1'b1;
            op_s       = OP_TRAP;
            addr_s     = ADDR_ILLEG;
            wdata_s    = pc_r;
            is_instr_s = 1'b0;
            retrap_s   = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        avail_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      gap_cnt_r    <= '0;
      busy_prev_r  <= 1'b0;
      is_instr_r   <= 1'b0;
      retrap_r     <= 1'b0;
      pc_r         <= 32'h0000_0000;
      avail_r      <= 1'b0;
      op_r         <= 3'b000;
      addr_r       <= 12'h000;
      wdata_r      <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      redirect_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      gap_cnt_r    <= gap_cnt_s;
      busy_prev_r  <= csr_busy;
      is_instr_r   <= is_instr_s;
      retrap_r     <= retrap_s;
      pc_r         <= pc_s;
      avail_r      <= avail_s;
      op_r         <= op_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      resp_valid_r <= resp_valid_s;
      rdata_r      <= rdata_s;
      redirect_r   <= redirect_s;
    end
  end

  assign req_ack       = ack_s & reset_n;
  assign csr_available = avail_r;
  assign csr_op        = op_r;
  assign csr_addr      = addr_r;
  assign csr_wdata     = wdata_r;
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = rdata_r;
  assign resp_redirect = redirect_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: CSR-unit stub, cycle-numbered transaction model,
// directed scenarios followed by randomized traffic.
module tb_trap_sequencer;
  localparam int MIN_GAP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exc_req = 1'b0;
  logic [3:0]  exc_code = 4'h0;
  logic        instr_req = 1'b0;
  logic [2:0]  instr_op = 3'b000;
  logic [11:0] instr_addr = 12'h000;
  logic [31:0] instr_wdata = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        at_boundary = 1'b0;
  logic        req_ack, csr_available, resp_valid, resp_redirect;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, resp_rdata;
  logic        csr_busy = 1'b0;
  logic        csr_fault = 1'b0;
  logic [31:0] csr_read_value = 32'h0;
  logic        ext_raw = 1'b0, sw_raw = 1'b0;
  int          trap_cnt = 0;
  int          mie_at = -1;
  wire         mie_s = (trap_cnt == mie_at);
  wire         ext_int_pending = ext_raw & mie_s;
  wire         sw_int_pending = sw_raw & mie_s;

  always #5 clk = ~clk;

  trap_sequencer #(.MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .exc_req(exc_req), .exc_code(exc_code),
    .instr_req(instr_req), .instr_op(instr_op), .instr_addr(instr_addr),
    .instr_wdata(instr_wdata), .pc(pc), .at_boundary(at_boundary),
    .req_ack(req_ack), .csr_available(csr_available), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_busy(csr_busy),
    .csr_fault(csr_fault), .csr_read_value(csr_read_value),
    .ext_int_pending(ext_int_pending), .sw_int_pending(sw_int_pending),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_redirect(resp_redirect)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // stub and model state
  logic [31:0] csr_mem [4096];
  int          k = 0, lat = 2, lat_force = 2, cyc = 0;
  bit          m_inflight = 0, m_retrap = 0, m_cur_instr = 0, m_prev_busy = 0;
  bit          m_resp_now = 0, m_redir = 0, arb = 0, prev_avail = 0;
  int          m_idle_from = 0, m_start_at = 0, win = 0;
  logic [2:0]  m_op = 3'b000;
  logic [11:0] m_addr = 12'h000;
  logic [31:0] m_wdata = 32'h0, m_pc = 32'h0, m_rdata = 32'h0;
  // observations used by directed literal checks
  int          ack_cnt = 0, ack_cyc = 0, resp_cnt = 0, resp_cyc = 0, avail_cnt = 0;
  int          low_cnt = 0, last_low_run = 0, last_rst_cyc = 0;
  bit          last_ack_exc = 0, cap_redir = 0;
  logic [11:0] cap_addr = 12'h000;
  logic [31:0] cap_wdata = 32'h0, cap_rdata = 32'h0;

  // CSR-unit stub, per-cycle comparison against the model, then model advance
  always @(negedge clk) begin
    if (cyc == 0) begin
      for (int a = 0; a < 4096; a++) csr_mem[a] = 32'hA500_0000 | 32'(a);
      csr_mem[12'h300] = 32'h0000_1800;
      csr_mem[12'h305] = 32'h0000_0010;
    end
    if (!csr_available) begin
      k = 0;
      csr_busy = 1'b0;
    end else begin
      k = k + 1;
      if (k == 1) lat = (lat_force != 0) ? lat_force : int'($urandom_range(3, 2));
      csr_busy = (k <= lat);
      csr_fault = (csr_op != 3'b000) && (csr_addr == 12'h341 || csr_addr[11:10] == 2'b11);
      csr_read_value = (csr_op == 3'b000) ? csr_mem[12'h305] : csr_mem[csr_addr];
      if (k == lat + 1) begin
        if (csr_op == 3'b000) trap_cnt = trap_cnt + 1;
        else if (!csr_fault && csr_op == 3'b010) csr_mem[csr_addr] = csr_wdata;
      end
    end

    arb = reset_n && !m_inflight && !m_retrap && (cyc >= m_idle_from);
    win = 0;
    if (arb) begin
      if (exc_req) win = 1;
      else if (ext_int_pending && at_boundary) win = 2;
      else if (sw_int_pending && at_boundary) win = 3;
      else if (instr_req) win = 4;
    end
    chk("req_ack", 32'(req_ack), 32'(win == 1 || win == 4));
    chk("csr_available", 32'(csr_available), 32'(m_inflight));
    if (m_inflight) begin
      chk("csr_op", 32'(csr_op), 32'(m_op));
      chk("csr_addr", 32'(csr_addr), 32'(m_addr));
      chk("csr_wdata", csr_wdata, m_wdata);
    end
    chk("resp_valid", 32'(resp_valid), 32'(m_resp_now));
    if (m_resp_now) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_redirect", 32'(resp_redirect), 32'(m_redir));
    end

    if (req_ack) begin ack_cnt++; ack_cyc = cyc; last_ack_exc = exc_req; end
    if (resp_valid) begin resp_cnt++; resp_cyc = cyc; cap_rdata = resp_rdata; cap_redir = resp_redirect; end
    if (csr_available) begin
      if (!prev_avail) begin last_low_run = low_cnt; cap_addr = csr_addr; cap_wdata = csr_wdata; end
      low_cnt = 0;
      avail_cnt++;
    end else begin
      low_cnt++;
    end
    prev_avail = csr_available;
    if (!reset_n) last_rst_cyc = cyc;

    m_resp_now = 0;
    if (!reset_n) begin
      m_inflight = 0; m_retrap = 0; m_idle_from = cyc + 1;
    end else if (m_inflight) begin
      if (m_prev_busy && !csr_busy) begin
        m_inflight = 0;
        m_idle_from = cyc + 1 + MIN_GAP;
        if (csr_fault) begin
          if (m_cur_instr) begin m_retrap = 1; m_start_at = cyc + 1 + MIN_GAP; end
        end else begin
          m_resp_now = 1; m_rdata = csr_read_value; m_redir = (m_op[2:1] == 2'b00);
        end
      end
    end else if (m_retrap) begin
      if (cyc + 1 == m_start_at) begin
        m_inflight = 1; m_retrap = 0; m_cur_instr = 0;
        m_op = 3'b000; m_addr = 12'h002; m_wdata = m_pc;
      end
    end else if (win != 0) begin
      m_inflight = 1;
      m_cur_instr = (win == 4);
      m_op = (win == 4) ? instr_op : 3'b000;
      m_wdata = (win == 4) ? instr_wdata : pc;
      case (win)
        1: m_addr = {8'h00, exc_code};
        2: m_addr = 12'h01B;
        3: m_addr = 12'h013;
        default: begin m_addr = instr_addr; m_pc = pc; end
      endcase
    end
    m_prev_busy = reset_n && csr_busy;
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ack(input int a0, input string nm);
    int i = 0;
    while (ack_cnt == a0 && i < 60) begin tick(1); i++; end
    if (ack_cnt == a0) chk(nm, 32'(ack_cnt), 32'(a0 + 1));
  endtask

  task automatic wait_resp(input int target, input string nm);
    int i = 0;
    while (resp_cnt < target && i < 60) begin tick(1); i++; end
    if (resp_cnt < target) chk(nm, 32'(resp_cnt), 32'(target));
  endtask

  task automatic issue_instr(input logic [2:0] op, input logic [11:0] addr,
                             input logic [31:0] wd, input logic [31:0] pcv, input string nm);
    int a0 = ack_cnt;
    instr_req = 1'b1; instr_op = op; instr_addr = addr; instr_wdata = wd; pc = pcv;
    wait_ack(a0, nm);
    instr_req = 1'b0;
  endtask

  logic [11:0] addr_tab [6] = '{12'h300, 12'h340, 12'h341, 12'h342, 12'hC00, 12'h7C0};
  int r0, a0, av0, seen_ack;

  initial begin
    tick(3);
    chk("rst_avail", 32'(csr_available), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_csr_addr", 32'(csr_addr), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // CSRRW mstatus
    r0 = resp_cnt; av0 = avail_cnt;
    issue_instr(3'b010, 12'h300, 32'd8, 32'h100, "d1_ack");
    a0 = ack_cyc;
    wait_resp(r0 + 1, "d1_resp");
    chk("d1_rdata", cap_rdata, 32'h0000_1800);
    chk("d1_redirect", 32'(cap_redir), 32'h0);
    chk("d1_latency", 32'(resp_cyc - a0), 32'd4);
    chk("d1_avail_cycles", 32'(avail_cnt - av0), 32'd3);
    tick(3);

    // exception beats a simultaneous instruction
    r0 = resp_cnt; a0 = ack_cnt;
    pc = 32'h200; exc_req = 1'b1; exc_code = 4'd2;
    instr_req = 1'b1; instr_op = 3'b010; instr_addr = 12'h340; instr_wdata = 32'd5;
    wait_ack(a0, "d2_exc_ack");
    exc_req = 1'b0;
    chk("d2_ack_is_exc", 32'(last_ack_exc), 32'h1);
    wait_resp(r0 + 1, "d2_trap_resp");
    chk("d2_addr", 32'(cap_addr), 32'h002);
    chk("d2_wdata", cap_wdata, 32'h200);
    chk("d2_rdata", cap_rdata, 32'h10);
    chk("d2_redirect", 32'(cap_redir), 32'h1);
    a0 = ack_cnt;
    wait_ack(a0, "d2_instr_ack");
    instr_req = 1'b0;
    chk("d2_instr_deferred", 32'(ack_cyc > resp_cyc), 32'h1);
    wait_resp(r0 + 2, "d2_instr_resp");
    tick(3);

    // external beats software; trap entry masks both
    r0 = resp_cnt;
    mie_at = trap_cnt; ext_raw = 1'b1; sw_raw = 1'b1; at_boundary = 1'b1; pc = 32'h400;
    wait_resp(r0 + 1, "d3_resp");
    chk("d3_addr", 32'(cap_addr), 32'h01B);
    chk("d3_wdata", cap_wdata, 32'h400);
    chk("d3_rdata", cap_rdata, 32'h10);
    chk("d3_redirect", 32'(cap_redir), 32'h1);
    tick(20);
    chk("d3_single_trap", 32'(resp_cnt - r0), 32'd1);
    ext_raw = 1'b0; sw_raw = 1'b0; at_boundary = 1'b0;

    // faulting instruction becomes an illegal-instruction trap
    r0 = resp_cnt;
    issue_instr(3'b010, 12'h341, 32'd7, 32'h300, "d4_ack");
    wait_resp(r0 + 1, "d4_resp");
    tick(10);
    chk("d4_single_resp", 32'(resp_cnt - r0), 32'd1);
    chk("d4_rdata", cap_rdata, 32'h10);
    chk("d4_redirect", 32'(cap_redir), 32'h1);
    chk("d4_trap_addr", 32'(cap_addr), 32'h002);
    chk("d4_trap_wdata", cap_wdata, 32'h300);
    chk("d4_gap_len", 32'(last_low_run), 32'(MIN_GAP));

    // reset drops an in-flight op; next request right after reset completes
    r0 = resp_cnt;
    issue_instr(3'b010, 12'h300, 32'd9, 32'h500, "d5_ack");
    tick(1);
    reset_n = 1'b0;
    a0 = ack_cnt;
    instr_req = 1'b1; instr_op = 3'b010; instr_addr = 12'h300; instr_wdata = 32'hA; pc = 32'h600;
    tick(1);
    reset_n = 1'b1;
    chk("d5_avail_after_rst", 32'(csr_available), 32'h0);
    chk("d5_resp_after_rst", 32'(resp_valid), 32'h0);
    chk("d5_op_after_rst", 32'(csr_op), 32'h0);
    wait_ack(a0, "d5_post_rst_ack");
    instr_req = 1'b0;
    chk("d5_ack_first_cycle", 32'(ack_cyc), 32'(last_rst_cyc + 1));
    wait_resp(r0 + 1, "d5_resp");
    tick(10);
    chk("d5_single_resp", 32'(resp_cnt - r0), 32'd1);
    chk("d5_rdata", cap_rdata, 32'd8);
    chk("d5_redirect", 32'(cap_redir), 32'h0);

    // interrupt held off while not at a boundary
    r0 = resp_cnt; av0 = avail_cnt;
    mie_at = trap_cnt; ext_raw = 1'b1; at_boundary = 1'b0;
    tick(10);
    chk("d6_no_avail", 32'(avail_cnt - av0), 32'h0);
    at_boundary = 1'b1;
    wait_resp(r0 + 1, "d6_resp");
    chk("d6_addr", 32'(cap_addr), 32'h01B);
    ext_raw = 1'b0; at_boundary = 1'b0;
    tick(6);

    // randomized traffic
    lat_force = 0;
    seen_ack = ack_cnt;
    for (int i = 0; i < 4000; i++) begin
      if (ack_cnt != seen_ack) begin
        seen_ack = ack_cnt;
        if (last_ack_exc) exc_req = 1'b0;
        else instr_req = 1'b0;
      end
      if (!exc_req && !instr_req) pc = $urandom;
      if (!exc_req && $urandom_range(15) == 0) begin exc_req = 1'b1; exc_code = 4'($urandom); end
      if (!instr_req && $urandom_range(3) == 0) begin
        instr_req = 1'b1; instr_op = 3'($urandom);
        instr_addr = addr_tab[$urandom_range(5)]; instr_wdata = $urandom;
      end
      ext_raw = 1'($urandom); sw_raw = 1'($urandom); at_boundary = 1'($urandom);
      if ($urandom_range(31) == 0) mie_at = trap_cnt;
      reset_n = ($urandom_range(299) != 0);
      tick(1);
    end
    exc_req = 1'b0; instr_req = 1'b0; ext_raw = 1'b0; sw_raw = 1'b0; reset_n = 1'b1;
    tick(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter MIN_GAP, default 2: minimum csr_available-low cycles between CSR-unit operations; values below 2 are illegal.
REQ-002 SHALL provide one clock and a synchronous, active-low reset, as the following ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  synchronous active-low reset
exc_req  in  1  core synchronous-exception request, held until req_ack
exc_code  in  4  exception cause code
instr_req  in  1  core CSR/MRET instruction request, held until req_ack
instr_op  in  3  CSR-unit op of instruction
instr_addr  in  12  CSR address of instruction
instr_wdata  in  32  CSR write operand
pc  in  32  PC of the pending request, or current boundary PC
at_boundary  in  1  core can take an interrupt this cycle
req_ack  out  1  one-cycle pulse: exc/instr request latched
csr_available  out  1  CSR-unit operation available
csr_op  out  3  CSR-unit op
csr_addr  out  12  CSR-unit address/exception value
csr_wdata  out  32  CSR-unit write value
csr_busy  in  1  CSR-unit busy
csr_fault  in  1  CSR-unit fault
csr_read_value  in  32  CSR-unit read value
ext_int_pending  in  1  enabled external interrupt pending
sw_int_pending  in  1  enabled software interrupt pending
resp_valid  out  1  one-cycle completion pulse to core
resp_rdata  out  32  CSR read data, or redirect target
resp_redirect  out  1  core SHALL jump to resp_rdata

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> GAP -> IDLE.
REQ-004 SHALL arbitrate only in IDLE, with fixed priority: exc_req > (ext_int_pending & at_boundary) > (sw_int_pending & at_boundary) > instr_req.
REQ-005 SHALL drive the winner as follows:
- exc: op 000, addr {8'b0,exc_code}, wdata pc
- ext: op 000, addr 12'h01B, wdata pc
- sw: op 000, addr 12'h013, wdata pc
- instr: instr_op/instr_addr/instr_wdata; pc latched internally
REQ-006 SHALL pulse req_ack in the arbitration cycle T for exc/instr winners only; a losing request receives no ack and stays pending.
REQ-007 SHALL drive csr_available=1 from T+1 and hold csr_op/csr_addr/csr_wdata stable while it is high.
REQ-008 SHALL detect completion in the cycle where csr_busy was 1 in the previous cycle and is 0 now (nominally T+3); csr_read_value and csr_fault SHALL be sampled there.
REQ-009 SHALL, on a non-faulting completion, set resp_valid=1 at T+4 with resp_rdata=sampled read value and resp_redirect=(op[2:1]==00); csr_available=0 from T+4.
REQ-010 SHALL, when an instruction-sourced op faults, suppress resp_valid and then, after GAP, auto-issue an illegal-instruction trap (op 000, addr 12'h002, wdata=latched pc); only that trap's completion produces resp_valid with redirect=1.
REQ-011 SHALL hold GAP for exactly MIN_GAP cycles with csr_available=0, using a counter cleared on entry, then return to IDLE.
REQ-012 SHALL NOT arbitrate in RUN or GAP; requests arriving there wait for IDLE.
REQ-013 SHALL NOT take an interrupt when at_boundary=0 in the arbitration cycle.

Reset
REQ-014 SHALL, when reset_n=0 at a clock edge, force IDLE, clear the gap counter and latched request, and drive all outputs to 0; in-flight operations are dropped with no resp_valid.
REQ-015 SHALL accept a new request in the first cycle after reset_n returns high.

Verification
REQ-016 SHALL cover these directed scenarios:
- CSRRW 0x300 wdata 8 at T -> req_ack T; csr_available T+1..T+3; resp_valid T+4, rdata=old mstatus, redirect 0.
- exc_req code 2 with instr_req in the same cycle -> csr_addr 12'h002, wdata=pc, redirect to 0x10; instr ack deferred to the next IDLE.
- ext and sw pending, at_boundary=1 -> addr 12'h01B taken, resp redirect 0x10; no second trap (sw gated by MIE).
- CSRRW 0x341 -> csr_fault; MIN_GAP idle cycles; trap addr 12'h002; single resp_valid, redirect=1, rdata 0x10.
- reset_n=0 at T+2 -> outputs 0 next cycle, no resp_valid; a following request completes normally.
- ext pending, at_boundary=0 for 10 cycles -> csr_available stays 0.
